// File: rtl/float_class_batch_pkg.sv
// Shared definitions for the batch float classifier: class bit positions,
// exponent constants and the controller state encoding.
package float_class_batch_pkg;

    // One-hot class bit positions
    localparam int CLS_ZERO = 0;
    localparam int CLS_NORM = 1;
    localparam int CLS_SUB  = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_NAN  = 4;
    localparam int NUM_CLS  = 5;

    // Exponent field value marking infinity / NaN
    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/float_classify.sv
// Combinational IEEE-754 single-precision classifier. Produces a one-hot
// class vector; the sign bit does not affect the class.
module float_classify
    import float_class_batch_pkg::*;
(
    input  logic [31:0]        operand,
    output logic [NUM_CLS-1:0] cls
);

    logic [7:0]  exp_field;
    logic [22:0] frac_field;
    logic        exp_zero;
    logic        exp_ones;
    logic        frac_zero;
    logic        unused_sign;

    assign exp_field   = operand[30:23];
    assign frac_field  = operand[22:0];
    assign unused_sign = operand[31];

    assign exp_zero  = (exp_field == 8'h00);
    assign exp_ones  = (exp_field == EXP_ALL1);
    assign frac_zero = (frac_field == 23'd0);

    // Decode the exponent/fraction combination into exactly one class bit
    always_comb begin
        cls           = '0;
        cls[CLS_ZERO] = exp_zero && frac_zero;
        cls[CLS_NORM] = !exp_zero && !exp_ones;
        cls[CLS_SUB]  = exp_zero && !frac_zero;
        cls[CLS_INF]  = exp_ones && frac_zero;
        cls[CLS_NAN]  = exp_ones && !frac_zero;
    end

endmodule

// File: rtl/float_class_batch.sv
// Batch controller: accepts `len` operands over valid/ready, classifies each
// with a single shared classifier and keeps a saturating count per class.
module float_class_batch
    import float_class_batch_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cnt_zero,
    output logic [CNT_W-1:0]   cnt_norm,
    output logic [CNT_W-1:0]   cnt_sub,
    output logic [CNT_W-1:0]   cnt_inf,
    output logic [CNT_W-1:0]   cnt_nan,
    output logic [NUM_CLS-1:0] last_type
);

    state_t               state_reg;
    state_t               state_next;
    logic [LEN_W-1:0]     remaining_reg;
    logic [NUM_CLS-1:0]   last_type_reg;
    logic [CNT_W-1:0]     cnt_reg [NUM_CLS];
    logic [NUM_CLS-1:0]   cls;
    logic                 start_accept;
    logic                 xfer;

    // Single classifier shared by every transfer
    float_classify u_classify (
        .operand (in_data),
        .cls     (cls)
    );

    // Handshake/status outputs come from the registered state only
    assign in_ready     = (state_reg == ST_RUN);
    assign busy         = (state_reg == ST_RUN);
    assign done         = (state_reg == ST_DONE);
    assign start_accept = (state_reg == ST_IDLE) && start;
    assign xfer         = in_ready && in_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; a zero-length batch goes straight to DONE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer && (remaining_reg == LEN_W'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Remaining-operand count and class of the latest accepted operand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_reg <= '0;
            last_type_reg <= '0;
        end else if (start_accept) begin
            remaining_reg <= len;
            last_type_reg <= '0;
        end else if (xfer) begin
            remaining_reg <= remaining_reg - LEN_W'(1);
            last_type_reg <= cls;
        end
    end

    // One saturating counter per class, bumped by its one-hot class bit
    generate
        for (genvar gi = 0; gi < NUM_CLS; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (start_accept) begin
                    cnt_reg[gi] <= '0;
                end else if (xfer && cls[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign cnt_zero  = cnt_reg[CLS_ZERO];
    assign cnt_norm  = cnt_reg[CLS_NORM];
    assign cnt_sub   = cnt_reg[CLS_SUB];
    assign cnt_inf   = cnt_reg[CLS_INF];
    assign cnt_nan   = cnt_reg[CLS_NAN];
    assign last_type = last_type_reg;

endmodule

// File: tb/tb_float_class_batch.sv
// Self-checking bench for float_class_batch. Two instances: A with 16-bit
// counters, B with 4-bit counters for saturation. A reference model
// classifies operands arithmetically and tracks expected counts.
module tb_float_class_batch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (CNT_W=16)
    logic        reset_a, start_a, valid_a;
    logic [7:0]  len_a;
    logic [31:0] data_a;
    logic        ready_a, busy_a, done_a;
    logic [15:0] cz_a, cn_a, cs_a, ci_a, cq_a;
    logic [4:0]  last_a;

    // Instance B (CNT_W=4)
    logic        reset_b, start_b, valid_b;
    logic [7:0]  len_b;
    logic [31:0] data_b;
    logic        ready_b, busy_b, done_b;
    logic [3:0]  cz_b, cn_b, cs_b, ci_b, cq_b;
    logic [4:0]  last_b;

    float_class_batch #(.CNT_W(16), .LEN_W(8)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .len(len_a),
        .in_valid(valid_a), .in_data(data_a), .in_ready(ready_a),
        .busy(busy_a), .done(done_a), .cnt_zero(cz_a), .cnt_norm(cn_a),
        .cnt_sub(cs_a), .cnt_inf(ci_a), .cnt_nan(cq_a), .last_type(last_a)
    );

    float_class_batch #(.CNT_W(4), .LEN_W(8)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .len(len_b),
        .in_valid(valid_b), .in_data(data_b), .in_ready(ready_b),
        .busy(busy_b), .done(done_b), .cnt_zero(cz_b), .cnt_norm(cn_b),
        .cnt_sub(cs_b), .cnt_inf(ci_b), .cnt_nan(cq_b), .last_type(last_b)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state per instance: counts indexed by class, last one-hot
    int ref_cnt  [2][5];
    int ref_last [2];

    // Class index from the IEEE-754 field rules
    function automatic int ref_class(logic [31:0] x);
        int e, f;
        e = int'(x >> 23) % 256;
        f = int'(x % 32'h0080_0000);
        if (e == 0)   return (f == 0) ? 0 : 2;
        if (e == 255) return (f == 0) ? 3 : 4;
        return 1;
    endfunction

    function automatic void model_clear(int sel);
        for (int k = 0; k < 5; k++) ref_cnt[sel][k] = 0;
        ref_last[sel] = 0;
    endfunction

    function automatic void model_accept(int sel, logic [31:0] x);
        int c, maxv;
        c    = ref_class(x);
        maxv = (sel == 0) ? 65535 : 15;
        if (ref_cnt[sel][c] < maxv) ref_cnt[sel][c] = ref_cnt[sel][c] + 1;
        ref_last[sel] = 1 << c;
    endfunction

    // Build a random operand of the requested class, random sign
    function automatic logic [31:0] rand_op(int c);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        case (c)
            0:       begin e = 8'h00; f = 23'd0; end
            1:       begin e = 8'($urandom_range(1, 254)); f = 23'($urandom); end
            2:       begin e = 8'h00; f = 23'($urandom_range(1, 23'h7FFFFF)); end
            3:       begin e = 8'hFF; f = 23'd0; end
            default: begin e = 8'hFF; f = 23'($urandom_range(1, 23'h7FFFFF)); end
        endcase
        return {s, e, f};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(int sel, bit st, logic [7:0] ln, bit v, logic [31:0] d);
        if (sel == 0) begin
            start_a = st; len_a = ln; valid_a = v; data_a = d;
        end else begin
            start_b = st; len_b = ln; valid_b = v; data_b = d;
        end
    endtask

    function automatic logic [31:0] o_cnt(int sel, int k);
        if (sel == 0) begin
            case (k)
                0: return 32'(cz_a);
                1: return 32'(cn_a);
                2: return 32'(cs_a);
                3: return 32'(ci_a);
                default: return 32'(cq_a);
            endcase
        end
        case (k)
            0: return 32'(cz_b);
            1: return 32'(cn_b);
            2: return 32'(cs_b);
            3: return 32'(ci_b);
            default: return 32'(cq_b);
        endcase
    endfunction

    // Compare every output of one instance against the model
    task automatic check_all(int sel, string tag, bit exp_busy, bit exp_done);
        chk({tag, ".busy"},  32'(sel == 0 ? busy_a  : busy_b),  32'(exp_busy));
        chk({tag, ".ready"}, 32'(sel == 0 ? ready_a : ready_b), 32'(exp_busy));
        chk({tag, ".done"},  32'(sel == 0 ? done_a  : done_b),  32'(exp_done));
        for (int k = 0; k < 5; k++)
            chk($sformatf("%s.cnt%0d", tag, k), o_cnt(sel, k), 32'(ref_cnt[sel][k]));
        chk({tag, ".last"}, 32'(sel == 0 ? last_a : last_b), 32'(ref_last[sel]));
    endtask

    // Run a whole batch. Valid comes from vpat if long enough, else random or 1.
    // With poke set, start is pulsed (and must be ignored) on idle RUN cycles.
    task automatic run_batch(int sel, string tag, logic [31:0] ops[$], bit vpat[$],
                             bit rnd_valid, bit poke);
        int n, taken, cyc;
        bit v;
        n = ops.size(); taken = 0; cyc = 0;
        drive(sel, 1'b1, 8'(n), 1'b0, 32'h0);
        @(posedge clk); #1;
        model_clear(sel);
        check_all(sel, {tag, ".start"}, n != 0, n == 0);
        while (taken < n && cyc < n * 10 + 20) begin
            if (vpat.size() > cyc) v = vpat[cyc];
            else if (rnd_valid)   v = 1'($urandom_range(0, 1));
            else                  v = 1'b1;
            drive(sel, poke && !v, 8'd7, v, v ? ops[taken] : 32'($urandom));
            @(posedge clk); #1;
            if (v) begin
                model_accept(sel, ops[taken]);
                taken++;
            end
            cyc++;
            check_all(sel, $sformatf("%s.c%0d", tag, cyc), taken < n, taken == n);
        end
        chk({tag, ".timeout"}, 32'(taken), 32'(n));
        // start during the DONE cycle must have no effect
        drive(sel, 1'b1, 8'd3, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 8'd0, 1'b0, 32'h0);
        check_all(sel, {tag, ".idle"}, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all(sel, {tag, ".idle2"}, 1'b0, 1'b0);
        $display("batch %s sel=%0d len=%0d cycles=%0d", tag, sel, n, cyc);
    endtask

    initial begin
        logic [31:0] q[$];
        bit          vp[$];
        bit          none[$];
        int          n;

        none = {};
        drive(0, 1'b0, 8'd0, 1'b0, 32'h0);
        drive(1, 1'b0, 8'd0, 1'b0, 32'h0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        model_clear(0);
        model_clear(1);
        #12;
        check_all(0, "reset_a", 1'b0, 1'b0);
        check_all(1, "reset_b", 1'b0, 1'b0);
        @(posedge clk); #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(posedge clk); #1;
        check_all(0, "post_reset", 1'b0, 1'b0);

        // One of each class, back-to-back
        q = {32'h0000_0000, 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
        run_batch(0, "classes", q, none, 1'b0, 1'b0);

        // Negative operands classify the same as positive ones
        q = {32'h8000_0000, 32'hFF80_0000, 32'h807F_FFFF, 32'hFFFF_FFFF};
        run_batch(0, "sign", q, none, 1'b0, 1'b0);

        // Zero-length batch: done the cycle after start, no ready
        q = {};
        run_batch(0, "len0", q, none, 1'b0, 1'b0);

        // Back-pressure with ignored start pulses while busy
        q  = {32'h3F80_0000, 32'h4000_0000, 32'h0040_0000};
        vp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_batch(0, "backpr", q, vp, 1'b0, 1'b1);

        // Saturation on the 4-bit instance
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(32'h7FC0_0001);
        run_batch(1, "sat", q, none, 1'b0, 1'b0);

        // Reset in the middle of a batch
        drive(0, 1'b1, 8'd10, 1'b0, 32'h0);
        @(posedge clk); #1;
        model_clear(0);
        for (int i = 0; i < 4; i++) begin
            q[0] = rand_op(int'($urandom_range(0, 4)));
            drive(0, 1'b0, 8'd0, 1'b1, q[0]);
            @(posedge clk); #1;
            model_accept(0, q[0]);
        end
        check_all(0, "mid_batch", 1'b1, 1'b0);
        reset_a = 1'b1;
        drive(0, 1'b0, 8'd0, 1'b0, 32'h0);
        #1;
        model_clear(0);
        check_all(0, "abort_async", 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all(0, "abort_hold", 1'b0, 1'b0);
        reset_a = 1'b0;
        @(posedge clk); #1;
        check_all(0, "abort_idle", 1'b0, 1'b0);
        q = {32'h0000_0000};
        run_batch(0, "restart", q, none, 1'b0, 1'b0);

        // Randomized batches on both instances
        for (int b = 0; b < 6; b++) begin
            q = {};
            n = (b == 5) ? 30 : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) q.push_back(rand_op(int'($urandom_range(0, 4))));
            run_batch(b == 5 ? 1 : 0, $sformatf("rnd%0d", b), q, none, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
